// File: rtl/uart_pkg.sv
// Shared UART types and elaboration helpers for the debug-path receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk, input int baud, input int os);
    return (clk + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks; clr re-phases it.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                  cnt <= '0;
    else if (clr || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, 16x oversampling with 3-sample majority,
// valid/ready byte output with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      rx_serial,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_frame_err,
  output logic                      rx_overrun,
  output logic [2:0]                rx_state
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_M0  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_M1  = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_DEC = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_END = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rxs;
  uart_rx_state_t            state;
  logic [SCW-1:0]            sc;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      smp0, smp1;
  logic                      start_edge, tick, decide, maj, done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_serial};
  end
  assign rxs = sync_q[1];

  // Re-phase the tick counter on the start edge so sc tracks bit centres.
  assign start_edge = (state == IDLE) && !rxs;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (start_edge),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else if (tick) begin
      if (sc == SC_M0) smp0 <= rxs;
      if (sc == SC_M1) smp1 <= rxs;
    end
  end

  // Third vote is the live sample on the decision tick.
  assign maj    = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
  assign decide = tick && (sc == SC_DEC);
  assign done   = (state == STOP) && decide && maj;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      sc           <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            sc    <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (decide && maj) begin
              state <= IDLE;
            end else if (sc == SC_END) begin
              state <= DATA;
              sc    <= '0;
              idx   <= '0;
            end else begin
              sc <= sc + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sc == SC_DEC) shreg[idx] <= maj;
            if (sc == SC_END) begin
              sc <= '0;
              if (idx == IDX_LAST) state <= STOP;
              else                 idx   <= idx + 1'b1;
            end else begin
              sc <= sc + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sc == SC_DEC) begin
              // Leave mid-stop-bit so the next start edge can be caught early.
              if (maj) begin
                state <= IDLE;
              end else begin
                state        <= BREAK;
                rx_frame_err <= 1'b1;
              end
            end else begin
              sc <= sc + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Same-cycle accept frees the slot, so the new byte loads without overrun.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a transaction-level model of the byte slot.
module tb_uart_rx;

  localparam int CF       = 1_600_000;
  localparam int BD       = 10_000;
  localparam int OS       = 16;
  localparam int BITC     = 160;
  localparam int FRAME    = 10 * BITC;
  localparam int DONE_CYC = 1542;  // frame-relative cycle in which the stop decision is made

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_overrun;
  logic [2:0] rx_state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  uart_rx #(.CLK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(OS)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_state     (rx_state)
  );

  // Pulse monitor: counts cycles each flag is high.
  int ovr_seen = 0, ferr_seen = 0, both_seen = 0, start_seen = 0;
  always @(negedge CLK) begin
    if (rx_overrun)                 ovr_seen++;
    if (rx_frame_err)               ferr_seen++;
    if (rx_overrun && rx_frame_err) both_seen++;
    if (rx_state == 3'd1)           start_seen++;
  end

  // Reference model of the single-byte output slot.
  bit         exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  int         exp_ovr = 0, exp_ferr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good, input bit acc_at_done);
    if (!good)                          exp_ferr++;
    else if (exp_valid && !acc_at_done) exp_ovr++;
    else begin
      exp_data  = b;
      exp_valid = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int rdy_cyc, input int ncyc);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      rx_serial = f[c / BITC];
      rx_ready  = (c == rdy_cyc);
    end
  endtask

  task automatic accept();
    @(negedge CLK);
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, rx_valid, exp_valid);
    if (exp_valid) chk({tag, "_data"}, rx_data, exp_data);
    chk({tag, "_ovr"}, ovr_seen, exp_ovr);
    chk({tag, "_ferr"}, ferr_seen, exp_ferr);
  endtask

  initial begin
    logic [7:0] b1, b2;
    int         s0, mode;

    repeat (3) @(negedge CLK);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_state", rx_state, 0);
    chk("rst_err", {rx_frame_err, rx_overrun}, 0);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);

    // Test 1: single byte held until accepted
    send_frame(8'hA5, 1'b1, -1, FRAME);
    model_frame(8'hA5, 1'b1, 1'b0);
    repeat (100) @(negedge CLK);
    chk("t1_data", rx_data, 8'hA5);
    check_model("t1");
    accept();
    chk("t1_acc", rx_valid, 0);
    check_model("t1b");

    // Test 2: back-to-back without accept -> one overrun, first byte kept
    send_frame(8'h55, 1'b1, -1, FRAME);
    model_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, -1, FRAME);
    model_frame(8'h3C, 1'b1, 1'b0);
    repeat (50) @(negedge CLK);
    chk("t2_data", rx_data, 8'h55);
    chk("t2_ovr", ovr_seen, 1);
    check_model("t2");
    accept();
    send_frame(8'h3C, 1'b1, -1, FRAME);
    model_frame(8'h3C, 1'b1, 1'b0);
    chk("t2_data2", rx_data, 8'h3C);
    check_model("t2b");
    accept();

    // Test 3: short glitch is a false start
    s0 = start_seen;
    @(negedge CLK);
    rx_serial = 1'b0;
    repeat (30) @(negedge CLK);
    rx_serial = 1'b1;
    repeat (200) @(negedge CLK);
    chk("t3_saw_start", start_seen > s0, 1);
    chk("t3_state", rx_state, 0);
    check_model("t3");

    // Test 4: bad stop bit, line held low -> frame error and BREAK
    send_frame(8'h81, 1'b0, -1, FRAME);
    model_frame(8'h81, 1'b0, 1'b0);
    repeat (500) @(negedge CLK);
    chk("t4_break", rx_state, 4);
    chk("t4_ferr", ferr_seen, 1);
    rx_serial = 1'b1;
    repeat (20) @(negedge CLK);
    chk("t4_idle", rx_state, 0);
    send_frame(8'h42, 1'b1, -1, FRAME);
    model_frame(8'h42, 1'b1, 1'b0);
    chk("t4_data", rx_data, 8'h42);
    check_model("t4");
    accept();

    // Test 5: accept coinciding with completion -> new byte loaded, no overrun
    send_frame(8'h11, 1'b1, -1, FRAME);
    model_frame(8'h11, 1'b1, 1'b0);
    s0 = ovr_seen;
    send_frame(8'h22, 1'b1, DONE_CYC, FRAME);
    model_frame(8'h22, 1'b1, 1'b1);
    chk("t5_valid", rx_valid, 1);
    chk("t5_data", rx_data, 8'h22);
    chk("t5_no_ovr", ovr_seen - s0, 0);
    check_model("t5");

    // Test 6: asynchronous reset mid-DATA with a byte pending
    send_frame(8'hF0, 1'b1, -1, 700);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_valid", rx_valid, 0);
    chk("t6_data", rx_data, 0);
    chk("t6_state", rx_state, 0);
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    rx_serial = 1'b1;
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    send_frame(8'h0F, 1'b1, -1, FRAME);
    model_frame(8'h0F, 1'b1, 1'b0);
    chk("t6_data2", rx_data, 8'h0F);
    check_model("t6");
    accept();

    // Randomized frames: single, overrun pair, or same-cycle accept pair
    for (int i = 0; i < 6; i++) begin
      b1   = 8'($urandom);
      b2   = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      send_frame(b1, 1'b1, -1, FRAME);
      model_frame(b1, 1'b1, 1'b0);
      if (mode != 0) begin
        send_frame(b2, 1'b1, (mode == 2) ? DONE_CYC : -1, FRAME);
        model_frame(b2, 1'b1, mode == 2);
      end
      repeat (int'($urandom_range(5, 300))) @(negedge CLK);
      check_model("rnd");
      accept();
      check_model("rnd_acc");
    end

    chk("no_coincident_err", both_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
